// File: rtl/result_readback_pkg.sv
// Shared definitions for the MCU GPIO responder: opcodes, status codes and response word layout.
// Opcode values are also consumed by ControlBlock, so they must stay in step with it.
package result_readback_pkg;

    localparam logic [2:0] OP_KERNEL  = 3'd0;
    localparam logic [2:0] OP_IMGSIZE = 3'd1;
    localparam logic [2:0] OP_IMG     = 3'd2;
    localparam logic [2:0] OP_REQ     = 3'd3;
    localparam logic [2:0] OP_RUN     = 3'd4;

    typedef enum logic [1:0] {
        STATUS_DATA  = 2'b00,
        STATUS_EMPTY = 2'b01,
        STATUS_DONE  = 2'b10,
        STATUS_OVF   = 2'b11
    } status_e;

    // Field order matches the GPIO word from bit 31 down to bit 0.
    typedef struct packed {
        logic       ack;
        status_e    status;
        logic [4:0] rsvd_hi;
        logic [7:0] fill;
        logic [7:0] rsvd_mid;
        logic [7:0] pixel;
    } resp_t;

    function automatic logic [31:0] pack_resp(
        input logic       ack,
        input status_e    status,
        input logic [7:0] fill,
        input logic [7:0] pixel
    );
        resp_t r;
        r.ack      = ack;
        r.status   = status;
        r.rsvd_hi  = '0;
        r.fill     = fill;
        r.rsvd_mid = '0;
        r.pixel    = (status == STATUS_DATA) ? pixel : '0;
        return r;
    endfunction

endpackage

// File: rtl/result_readback_sync_fifo.sv
// Synchronous FIFO with fill count and flush; head is read combinationally at rd_ptr.
// Push while full and pop while empty are ignored.
module sync_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned W     = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   push,
    input  logic                   pop,
    input  logic [W-1:0]           wdata,
    output logic [W-1:0]           head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [W-1:0]  mem_q [DEPTH];
    logic          do_push;
    logic          do_pop;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign head    = mem_q[rd_ptr_q];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/result_readback.sv
// Data_request responder: buffers convolved pixels and returns one per MCU request
// in a 32-bit GPIO word carrying an ACK toggle, status and post-operation fill level.
module result_readback
    import result_readback_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned PIX_W = 8
) (
    input  logic             i_CLK,
    input  logic             i_rst,
    input  logic [2:0]       i_GPIOctrl,
    input  logic             i_GPIOvalid,
    input  logic [PIX_W-1:0] i_pixel,
    input  logic             i_pixel_valid,
    input  logic             i_EOP_from_FSM,
    output logic             o_pixel_ready,
    output logic [31:0]      o_GPIOdata,
    output logic             o_overflow
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic        vprev_q, vprev_d;
    logic        ack_q, ack_d;
    logic        eop_seen_q, eop_seen_d;
    logic        overflow_q, overflow_d;
    logic [31:0] gpio_data_q, gpio_data_d;

    logic             cmd_edge;
    logic             req_cmd;
    logic             load_cmd;
    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [PIX_W-1:0] fifo_head;
    logic [AW:0]      fifo_count;
    logic [AW:0]      fill_after;
    status_e          status;

    assign cmd_edge  = i_GPIOvalid & ~vprev_q;
    assign req_cmd   = cmd_edge & (i_GPIOctrl == OP_REQ);
    assign load_cmd  = cmd_edge & (i_GPIOctrl == OP_IMG);
    // Readiness comes from the registered fill, so a pop cannot make room in the same cycle.
    assign fifo_push = i_pixel_valid & ~fifo_full;
    assign fifo_pop  = req_cmd & ~fifo_empty;

    sync_fifo #(
        .DEPTH (DEPTH),
        .W     (PIX_W)
    ) u_fifo (
        .clk   (i_CLK),
        .rst   (i_rst),
        .flush (load_cmd),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata (i_pixel),
        .head  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        fill_after = fifo_count;
        if (fifo_push && !fifo_pop) fill_after = fifo_count + 1'b1;
        if (fifo_pop && !fifo_push) fill_after = fifo_count - 1'b1;
    end

    always_comb begin
        if (overflow_q)       status = STATUS_OVF;
        else if (!fifo_empty) status = STATUS_DATA;
        else if (eop_seen_q)  status = STATUS_DONE;
        else                  status = STATUS_EMPTY;
    end

    always_comb begin
        vprev_d     = i_GPIOvalid;
        ack_d       = ack_q;
        gpio_data_d = gpio_data_q;
        eop_seen_d  = eop_seen_q | i_EOP_from_FSM;
        overflow_d  = overflow_q | (i_pixel_valid & fifo_full);
        if (req_cmd) begin
            ack_d       = ~ack_q;
            gpio_data_d = pack_resp(~ack_q, status, 8'(fill_after), 8'(fifo_head));
        end
        if (load_cmd) begin
            eop_seen_d = 1'b0;
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge i_CLK) begin
        if (i_rst) begin
            vprev_q     <= 1'b0;
            ack_q       <= 1'b0;
            eop_seen_q  <= 1'b0;
            overflow_q  <= 1'b0;
            gpio_data_q <= '0;
        end else begin
            vprev_q     <= vprev_d;
            ack_q       <= ack_d;
            eop_seen_q  <= eop_seen_d;
            overflow_q  <= overflow_d;
            gpio_data_q <= gpio_data_d;
        end
    end

    assign o_pixel_ready = ~fifo_full;
    assign o_overflow    = overflow_q;
    assign o_GPIOdata    = gpio_data_q;

endmodule
